// File: rtl/instr_fetch_unit.sv
// Instruction-fetch front end: owns the PC, fetches over a req/ack handshake,
// and redirects on jr/branch (EX) and j (ID), inserting NOP bubbles as needed.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch,
    input  logic        jr,
    input  logic        jump,
    input  logic [25:0] jump_target,
    input  logic [31:0] seOut,
    input  logic [31:0] reg_Da,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instructions,
    output logic        inst_valid,
    output logic [31:0] pc_out,
    output logic        flush,
    output logic        fetch_err
);

    // state   | meaning
    // S_FETCH | requesting imem, accepting acks and redirects
    // S_ERROR | imem timed out; idle with NOP output until reset
    typedef enum logic {
        S_FETCH,
        S_ERROR
    } state_t;

    localparam logic [31:0] NOP       = 32'h0000_0000;
    localparam logic [31:0] PC_ALIGN  = {RESET_PC[31:2], 2'b00};
    localparam logic [7:0]  WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_n;
    logic [31:0] fetch_pc_q, fetch_pc_n;
    logic [31:0] pc_out_q, pc_out_n;
    logic [31:0] pc_d_q, pc_d_n;
    logic [31:0] pc_e_q, pc_e_n;
    logic [31:0] instr_q, instr_n;
    logic        valid_q, valid_n;
    logic        flush_q, flush_n;
    logic        err_q, err_n;
    logic [7:0]  wait_q, wait_n;
    logic [31:0] redirect_pc;
    logic [31:0] pc_d_inc;
    logic        ex_redirect;

    assign ex_redirect = jr | branch;

    always_comb begin
        pc_d_inc = pc_d_q + 32'd4;
        if (jr) begin
            redirect_pc = {reg_Da[31:2], 2'b00};
        end else if (branch) begin
            redirect_pc = pc_e_q + 32'd4 + {seOut[29:0], 2'b00};
        end else begin
            redirect_pc = {pc_d_inc[31:28], jump_target, 2'b00};
        end
    end

    always_comb begin
        state_n    = state_q;
        fetch_pc_n = fetch_pc_q;
        pc_out_n   = pc_out_q;
        pc_d_n     = pc_d_q;
        pc_e_n     = pc_e_q;
        instr_n    = instr_q;
        valid_n    = valid_q;
        flush_n    = 1'b0;
        err_n      = err_q;
        wait_n     = wait_q;

        if (!stall) begin
            pc_d_n = pc_out_q;
            pc_e_n = pc_d_q;
            if (state_q == S_FETCH) begin
                if (ex_redirect || jump) begin
                    // any ack in the redirect cycle belongs to the wrong path
                    fetch_pc_n = redirect_pc;
                    instr_n    = NOP;
                    valid_n    = 1'b0;
                    flush_n    = ex_redirect;
                    wait_n     = 8'd0;
                end else if (imem_ack) begin
                    instr_n    = imem_rdata;
                    valid_n    = 1'b1;
                    pc_out_n   = fetch_pc_q;
                    fetch_pc_n = fetch_pc_q + 32'd4;
                    wait_n     = 8'd0;
                end else begin
                    instr_n = NOP;
                    valid_n = 1'b0;
                    wait_n  = wait_q + 8'd1;
                    if (wait_q == WAIT_LAST) begin
                        err_n   = 1'b1;
                        state_n = S_ERROR;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FETCH;
            fetch_pc_q <= PC_ALIGN;
            pc_out_q   <= RESET_PC;
            pc_d_q     <= 32'd0;
            pc_e_q     <= 32'd0;
            instr_q    <= NOP;
            valid_q    <= 1'b0;
            flush_q    <= 1'b0;
            err_q      <= 1'b0;
            wait_q     <= 8'd0;
        end else begin
            state_q    <= state_n;
            fetch_pc_q <= fetch_pc_n;
            pc_out_q   <= pc_out_n;
            pc_d_q     <= pc_d_n;
            pc_e_q     <= pc_e_n;
            instr_q    <= instr_n;
            valid_q    <= valid_n;
            flush_q    <= flush_n;
            err_q      <= err_n;
            wait_q     <= wait_n;
        end
    end

    assign imem_req     = (state_q == S_FETCH) && !stall;
    assign imem_addr    = fetch_pc_q;
    assign Instructions = instr_q;
    assign inst_valid   = valid_q;
    assign pc_out       = pc_out_q;
    assign flush        = flush_q;
    assign fetch_err    = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, then random stimulus
// checked against a cycle-level reference model of the fetch rules.
module tb_instr_fetch_unit;

    localparam logic [31:0] RPC = 32'h0040_0000;
    localparam int          TO  = 4;

    logic        clk = 1'b0;
    logic        rst, stall, branch, jr, jump, imem_ack;
    logic [25:0] jump_target;
    logic [31:0] seOut, reg_Da, imem_rdata;
    logic        imem_req, inst_valid, flush, fetch_err;
    logic [31:0] imem_addr, Instructions, pc_out;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(RPC), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .stall(stall), .branch(branch), .jr(jr),
        .jump(jump), .jump_target(jump_target), .seOut(seOut), .reg_Da(reg_Da),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .Instructions(Instructions),
        .inst_valid(inst_valid), .pc_out(pc_out), .flush(flush),
        .fetch_err(fetch_err)
    );

    typedef struct {
        logic        rst, stall, br, jr, jmp;
        logic [25:0] jt;
        logic [31:0] se, da;
        logic        ack;
        logic [31:0] rd;
        logic        e_req;
        logic [31:0] e_addr, e_ins;
        logic        e_val;
        logic [31:0] e_pc;
        logic        e_fl, e_err;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // reference model state
    logic [31:0] m_fetch, m_pc_out, m_pc_d, m_pc_e, m_ins;
    logic        m_val, m_fl, m_err;
    int          m_miss;

    function automatic vec_t mk(input logic r, s, b, j, jm, input logic [25:0] jt,
                                input logic [31:0] se, da, input logic ack,
                                input logic [31:0] rd, input logic e_req,
                                input logic [31:0] e_addr, e_ins, input logic e_val,
                                input logic [31:0] e_pc, input logic e_fl, e_err);
        vec_t v;
        v.rst = r; v.stall = s; v.br = b; v.jr = j; v.jmp = jm; v.jt = jt;
        v.se = se; v.da = da; v.ack = ack; v.rd = rd; v.e_req = e_req;
        v.e_addr = e_addr; v.e_ins = e_ins; v.e_val = e_val; v.e_pc = e_pc;
        v.e_fl = e_fl; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst; stall = v.stall; branch = v.br; jr = v.jr; jump = v.jmp;
        jump_target = v.jt; seOut = v.se; reg_Da = v.da;
        imem_ack = v.ack; imem_rdata = v.rd;
    endtask

    task automatic model_edge();
        logic [31:0] tgt;
        if (rst) begin
            m_fetch = RPC; m_pc_out = RPC; m_pc_d = 0; m_pc_e = 0;
            m_ins = 0; m_val = 0; m_fl = 0; m_err = 0; m_miss = 0;
            return;
        end
        m_fl = 0;
        if (stall) return;
        if (jr)          tgt = reg_Da - (reg_Da % 4);
        else if (branch) tgt = m_pc_e + 4 + seOut * 4;
        else             tgt = ((m_pc_d + 4) & 32'hF000_0000) | ({6'b0, jump_target} * 32'd4);
        m_pc_e = m_pc_d;
        m_pc_d = m_pc_out;
        if (m_err) return;
        if (jr || branch || jump) begin
            m_fetch = tgt; m_ins = 0; m_val = 0; m_fl = jr | branch; m_miss = 0;
        end else if (imem_ack) begin
            m_ins = imem_rdata; m_val = 1; m_pc_out = m_fetch;
            m_fetch = m_fetch + 4; m_miss = 0;
        end else begin
            m_ins = 0; m_val = 0; m_miss++;
            if (m_miss == TO) m_err = 1;
        end
    endtask

    task automatic check_vec(input int i, input vec_t v);
        chk($sformatf("v%0d req", i),   {31'b0, imem_req},   {31'b0, v.e_req});
        chk($sformatf("v%0d addr", i),  imem_addr,           v.e_addr);
        chk($sformatf("v%0d instr", i), Instructions,        v.e_ins);
        chk($sformatf("v%0d valid", i), {31'b0, inst_valid}, {31'b0, v.e_val});
        chk($sformatf("v%0d pc", i),    pc_out,              v.e_pc);
        chk($sformatf("v%0d flush", i), {31'b0, flush},      {31'b0, v.e_fl});
        chk($sformatf("v%0d err", i),   {31'b0, fetch_err},  {31'b0, v.e_err});
    endtask

    task automatic check_model(input int i);
        chk($sformatf("r%0d req", i),   {31'b0, imem_req},   {31'b0, (!m_err && !stall)});
        chk($sformatf("r%0d addr", i),  imem_addr,           m_fetch);
        chk($sformatf("r%0d instr", i), Instructions,        m_ins);
        chk($sformatf("r%0d valid", i), {31'b0, inst_valid}, {31'b0, m_val});
        chk($sformatf("r%0d pc", i),    pc_out,              m_pc_out);
        chk($sformatf("r%0d flush", i), {31'b0, flush},      {31'b0, m_fl});
        chk($sformatf("r%0d err", i),   {31'b0, fetch_err},  {31'b0, m_err});
    endtask

    initial begin
        logic [15:0] imm;
        vec_t        rv;

        // rst stall br jr jmp jt se da ack rd | req addr instr valid pc flush err
        vecs.push_back(mk(0,0,0,0,0,0,0,0,1,32'h0040_0000, 1,32'h0040_0000,32'h0,0,32'h0040_0000,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,1,32'h0040_0004, 1,32'h0040_0004,32'h0040_0000,1,32'h0040_0000,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,1,32'h0040_0008, 1,32'h0040_0008,32'h0040_0004,1,32'h0040_0004,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,32'h0,         1,32'h0040_000C,32'h0040_0008,1,32'h0040_0008,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,1,32'h0040_000C, 1,32'h0040_000C,32'h0,0,32'h0040_0008,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,32'h0,         1,32'h0040_0010,32'h0040_000C,1,32'h0040_000C,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,1,32'h0040_0010, 1,32'h0040_0010,32'h0,0,32'h0040_000C,0,0));
        vecs.push_back(mk(0,1,0,0,0,0,0,0,0,32'h0,         0,32'h0040_0014,32'h0040_0010,1,32'h0040_0010,0,0));
        vecs.push_back(mk(0,1,0,0,0,0,0,0,1,32'hDEAD_BEEF, 0,32'h0040_0014,32'h0040_0010,1,32'h0040_0010,0,0));
        vecs.push_back(mk(0,1,0,0,0,0,0,0,0,32'h0,         0,32'h0040_0014,32'h0040_0010,1,32'h0040_0010,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,1,32'h0040_0014, 1,32'h0040_0014,32'h0040_0010,1,32'h0040_0010,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,32'h0,         1,32'h0040_0018,32'h0040_0014,1,32'h0040_0014,0,0));
        // jr to 0x100 (coincident ack dropped), then build pc_e = 0x100
        vecs.push_back(mk(0,0,0,1,0,0,0,32'h103,1,32'hAAAA, 1,32'h0040_0018,32'h0,0,32'h0040_0014,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,1,32'h1111_1111, 1,32'h100,32'h0,0,32'h0040_0014,1,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,32'h0,         1,32'h104,32'h1111_1111,1,32'h100,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,32'h0,         1,32'h104,32'h0,0,32'h100,0,0));
        vecs.push_back(mk(0,0,1,0,0,0,32'hFFFF_FFFE,0,1,32'h2222, 1,32'h104,32'h0,0,32'h100,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,32'h0,         1,32'hFC,32'h0,0,32'h100,1,0));
        vecs.push_back(mk(0,0,1,1,0,0,32'hFFFF_FFFE,32'h2003,1,32'h3333, 1,32'hFC,32'h0,0,32'h100,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,32'h0,         1,32'h2000,32'h0,0,32'h100,1,0));
        // set up pc_d = 0x8000_0010 for the jump
        vecs.push_back(mk(0,0,0,1,0,0,0,32'h8000_0010,0,32'h0, 1,32'h2000,32'h0,0,32'h100,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,1,32'h4444_4444, 1,32'h8000_0010,32'h0,0,32'h100,1,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,32'h0,         1,32'h8000_0014,32'h4444_4444,1,32'h8000_0010,0,0));
        vecs.push_back(mk(0,0,0,0,1,26'h40,0,0,1,32'h5555, 1,32'h8000_0014,32'h0,0,32'h8000_0010,0,0));
        // four unanswered requests -> timeout
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,32'h0, 1,32'h8000_0100,32'h0,0,32'h8000_0010,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,32'h0, 1,32'h8000_0100,32'h0,0,32'h8000_0010,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,32'h0, 1,32'h8000_0100,32'h0,0,32'h8000_0010,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,32'h0, 1,32'h8000_0100,32'h0,0,32'h8000_0010,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,32'h0, 0,32'h8000_0100,32'h0,0,32'h8000_0010,0,1));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,1,32'h6666, 0,32'h8000_0100,32'h0,0,32'h8000_0010,0,1));
        vecs.push_back(mk(1,0,0,0,0,0,0,0,1,32'h7777, 0,32'h8000_0100,32'h0,0,32'h8000_0010,0,1));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,1,32'h0040_0000, 1,32'h0040_0000,32'h0,0,32'h0040_0000,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,32'h0, 1,32'h0040_0004,32'h0040_0000,1,32'h0040_0000,0,0));

        // reset: two cycles, check reset values during the second
        rv = mk(1,0,0,0,0,0,0,0,0,0, 1,RPC,32'h0,0,RPC,0,0);
        @(negedge clk); drive(rv);
        @(posedge clk); model_edge();
        @(negedge clk); drive(rv); #1;
        check_vec(-1, rv);
        @(posedge clk); model_edge();

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check_vec(i, vecs[i]);
            @(posedge clk);
            model_edge();
        end

        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            rst    = ($urandom_range(0, 63) == 0) || (m_err && $urandom_range(0, 3) == 0);
            stall  = ($urandom_range(0, 4) == 0);
            jr     = ($urandom_range(0, 11) == 0);
            branch = ($urandom_range(0, 11) == 0);
            jump   = ($urandom_range(0, 11) == 0);
            jump_target = 26'($urandom);
            imm    = 16'($urandom);
            seOut  = {{16{imm[15]}}, imm};
            reg_Da = $urandom;
            imem_ack   = ($urandom_range(0, 9) < 7);
            imem_rdata = $urandom;
            #1;
            check_model(c);
            @(posedge clk);
            model_edge();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
